// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: stall/flush decisions for load-use, taken branches and
// multi-cycle data-memory accesses, plus a MEM wait watchdog and saturating counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mw;
  logic rs1_hit;
  logic rs2_hit;
  logic lu;

  assign mw      = mem_req & ~mem_ready;
  assign rs1_hit = id_re1 & (id_rs1 == ex_wR);
  assign rs2_hit = id_re2 & (id_rs2 == ex_wR);
  // x0 is hard-wired zero, so a load targeting it never produces a hazard.
  assign lu      = ex_is_load & ex_rf_we & (ex_wR != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      if ((state_q == ERR) || mw) begin
        // Full freeze; a pending branch or load-use is re-evaluated once it lifts.
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        if (mw) begin
          state_d    = WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      WAIT: begin
        // Ready or a dropped request both end the access.
        if (!mw) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
          state_d   = ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if ((if_id_flush || id_ex_flush) && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (short timeout, narrow counters, defaults)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_wR;
  logic       id_re1, id_re2, ex_rf_we, ex_is_load, ex_br_taken, mem_req, mem_ready;

  logic pc_s[3], ifid_s[3], ifid_f[3], idex_s[3], idex_f[3], exmem_s[3], memwb_f[3], tmo_o[3];
  logic [31:0] sc0, fc0, sc2, fc2;
  logic [3:0]  sc1, fc1;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic [6:0] FREEZE = 7'b1101011;
  localparam logic [6:0] BRANCH = 7'b0010100;
  localparam logic [6:0] LOADU  = 7'b1100100;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_s[0]), .if_id_stall(ifid_s[0]),
    .if_id_flush(ifid_f[0]), .id_ex_stall(idex_s[0]), .id_ex_flush(idex_f[0]),
    .ex_mem_stall(exmem_s[0]), .mem_wb_flush(memwb_f[0]), .mem_timeout(tmo_o[0]),
    .stall_cnt(sc0), .flush_cnt(fc0));

  hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_s[1]), .if_id_stall(ifid_s[1]),
    .if_id_flush(ifid_f[1]), .id_ex_stall(idex_s[1]), .id_ex_flush(idex_f[1]),
    .ex_mem_stall(exmem_s[1]), .mem_wb_flush(memwb_f[1]), .mem_timeout(tmo_o[1]),
    .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_ctrl dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_stall(pc_s[2]), .if_id_stall(ifid_s[2]),
    .if_id_flush(ifid_f[2]), .id_ex_stall(idex_s[2]), .id_ex_flush(idex_f[2]),
    .ex_mem_stall(exmem_s[2]), .mem_wb_flush(memwb_f[2]), .mem_timeout(tmo_o[2]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  // Reference model: consecutive-wait count, sticky error, counters as plain integers.
  int    m_tmo[3] = '{4, 64, 16};
  longint m_max[3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
  longint m_sc[3], m_fc[3];
  int    m_waits[3];
  bit    m_err[3];

  function automatic logic [6:0] dut_ctl(int k);
    return {pc_s[k], ifid_s[k], ifid_f[k], idex_s[k], idex_f[k], exmem_s[k], memwb_f[k]};
  endfunction

  function automatic logic [6:0] model_ctl(int k);
    bit hit;
    hit = ex_is_load && ex_rf_we && (ex_wR != 5'd0) &&
          ((id_re1 && id_rs1 == ex_wR) || (id_re2 && id_rs2 == ex_wR));
    if (rst) return 7'b0;
    if (m_err[k] || (mem_req && !mem_ready)) return FREEZE;
    if (ex_br_taken) return BRANCH;
    if (hit) return LOADU;
    return 7'b0;
  endfunction

  task automatic model_step();
    logic [6:0] c;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_err[k] = 0; m_waits[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else begin
        c = model_ctl(k);
        if (c[6] && m_sc[k] < m_max[k]) m_sc[k]++;
        if ((c[4] || c[2]) && m_fc[k] < m_max[k]) m_fc[k]++;
        if (!m_err[k]) begin
          if (mem_req && !mem_ready) begin
            m_waits[k]++;
            if (m_waits[k] >= m_tmo[k]) m_err[k] = 1;
          end else begin
            m_waits[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called after inputs are driven at a negedge; checks controls, clocks, checks state.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ctl%0d", k), longint'(dut_ctl(k)), longint'(model_ctl(k)));
    @(posedge clk);
    model_step();
    #1;
    chk("stall_cnt0", longint'(sc0), m_sc[0]);
    chk("flush_cnt0", longint'(fc0), m_fc[0]);
    chk("stall_cnt1", longint'(sc1), m_sc[1]);
    chk("flush_cnt1", longint'(fc1), m_fc[1]);
    chk("stall_cnt2", longint'(sc2), m_sc[2]);
    chk("flush_cnt2", longint'(fc2), m_fc[2]);
    for (int k = 0; k < 3; k++) chk($sformatf("timeout%0d", k), longint'(tmo_o[k]), longint'(m_err[k]));
    @(negedge clk);
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] wr,
                        input logic re1, input logic re2, input logic we, input logic ld,
                        input logic br, input logic req, input logic rdy);
    id_rs1 = rs1; id_rs2 = rs2; ex_wR = wr; id_re1 = re1; id_re2 = re2;
    ex_rf_we = we; ex_is_load = ld; ex_br_taken = br; mem_req = req; mem_ready = rdy;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, wr;
    logic       re1, re2, we, ld, br, req, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LOADU};
    tbl[1]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0};
    tbl[2]  = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0};
    tbl[3]  = '{5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, LOADU};
    tbl[4]  = '{5'd7, 5'd2, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0};
    tbl[5]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0};
    tbl[6]  = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0};
    tbl[7]  = '{5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, BRANCH};
    tbl[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BRANCH};
    tbl[9]  = '{5'd3, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, LOADU};
    tbl[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b0};
    tbl[11] = '{5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0};

    // Reset with a live load-use on the inputs: controls must stay low.
    set_in(5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_stall_cnt", longint'(sc2), 0);
    chk("reset_timeout", longint'(tmo_o[2]), 0);

    // Table of single-cycle RUN-state decisions.
    idle();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].wr, tbl[i].re1, tbl[i].re2,
             tbl[i].we, tbl[i].ld, tbl[i].br, tbl[i].req, tbl[i].rdy);
      #1;
      chk($sformatf("tbl%0d", i), longint'(dut_ctl(2)), longint'(tbl[i].exp));
      tick();
    end

    // Load-use: one stall cycle, then clear.
    do_reset();
    set_in(5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("lu_clear", longint'(dut_ctl(2)), 0);
    tick();
    chk("lu_stall_cnt", longint'(sc2), 1);
    chk("lu_flush_cnt", longint'(fc2), 1);

    // Three wait cycles with a held-off branch, flushed when ready arrives.
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_freeze", longint'(dut_ctl(2)), longint'(FREEZE));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_release_branch", longint'(dut_ctl(2)), longint'(BRANCH));
    tick();
    idle();
    tick();
    chk("wait_stall_cnt", longint'(sc2), 3);
    chk("wait_flush_cnt", longint'(fc2), 1);
    chk("wait_no_timeout", longint'(tmo_o[0]), 0);

    // Watchdog on dut0 (timeout 4), frozen until reset.
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("tmo_not_yet", longint'(tmo_o[0]), 0);
    tick();
    chk("tmo_fired", longint'(tmo_o[0]), 1);
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("err_frozen", longint'(dut_ctl(0)), longint'(FREEZE));
      tick();
    end
    do_reset();
    #1;
    chk("err_reset_ctl", longint'(dut_ctl(0)), 0);
    chk("err_reset_tmo", longint'(tmo_o[0]), 0);
    chk("err_reset_cnt", longint'(sc0), 0);

    // Default timeout 16: 15 waits then ready is legal, 16 waits is not.
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    mem_ready = 1'b1;
    tick();
    chk("tmo16_legal", longint'(tmo_o[2]), 0);
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    chk("tmo16_fired", longint'(tmo_o[2]), 1);

    // Narrow counters saturate.
    do_reset();
    set_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", longint'(sc1), 15);
    chk("sat_no_timeout", longint'(tmo_o[1]), 0);

    // Randomized traffic against the model.
    idle();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 39) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_wR       = 5'($urandom_range(0, 3));
      id_re1      = 1'($urandom);
      id_re2      = 1'($urandom);
      ex_rf_we    = ($urandom_range(0, 3) != 0);
      ex_is_load  = 1'($urandom);
      ex_br_taken = ($urandom_range(0, 4) == 0);
      mem_req     = ($urandom_range(0, 9) < 4);
      mem_ready   = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
